ii_loop_issuer: RTL and testbench
=================================

# ii_loop_issuer

Parametrised two-level loop-nest issue controller, the generalised successor to the single-level every-II counter. On a `start` pulse it issues `TRIPS_OUTER*TRIPS_INNER` iterations, one every `II` cycles. Each issue carries outer/inner loop indices, and the block supports stalls, a final-iteration flag, a done pulse and back-to-back restart. It sits between a stage controller and the pipelined datapath it sequences.

## Interface
- `WIDTH`, 32, width of the index outputs; must satisfy `TRIPS_OUTER <= 2**WIDTH` and `TRIPS_INNER <= 2**WIDTH`.
- `TRIPS_OUTER`, 2, outer trip count, ≥1.
- `TRIPS_INNER`, 4, inner trip count, ≥1.
- `II`, 1, initiation interval in cycles between issues, ≥1.
- `clk` in 1: clock, rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a run; sampled on rising edge.
- `stall` in 1: freeze the run for this cycle.
- `busy` out 1: run in progress.
- `issue` out 1: iteration issued this cycle.
- `idx_outer` out WIDTH: outer index of the current iteration.
- `idx_inner` out WIDTH: inner index of the current iteration.
- `last` out 1: this issue is the final iteration.
- `done` out 1: one-cycle pulse, cycle after the final issue.

## Operation
- States: IDLE, RUN. `busy` = (state==RUN). All outputs are 0 after reset.
- Gap counter `gap`, range 0..II-1. `issue` = RUN & gap==0 & !stall; this is combinational on `stall`.
- **IDLE:**
  - `start` moves to RUN next cycle with gap=0 and indices (0,0).
  - `stall` has no effect.
- **RUN, issue cycle:**
  - `idx_inner` increments.
  - At TRIPS_INNER-1, `idx_inner` wraps to 0 and `idx_outer` increments.
  - gap ← (II==1 ? 0 : 1).
- **RUN, non-issue, not stalled:** gap ← (gap==II-1 ? 0 : gap+1).
- **Stall in RUN:** gap and indices hold. An issue due in a stalled cycle is postponed, not dropped.
- **`last`:** `last` = issue & idx_outer==TRIPS_OUTER-1 & idx_inner==TRIPS_INNER-1.
- **Leaving RUN:**
  - On a `last` cycle the state returns to IDLE and the indices to (0,0).
  - `done` is registered: high in the following cycle only.
- **`start` while busy:**
  - Ignored, except in the `last` cycle.
  - `start` coincident with `last` restarts: RUN continues, indices go to (0,0), gap goes to 0.
  - `done` still pulses for the completed run.
- **Reset mid-run:** IDLE next cycle, indices 0, no `done` pulse. A pending registered `done` is cleared.
- Index outputs are meaningful only while `issue` is high; in IDLE they read 0.
- Arithmetic: counters are WIDTH bits. Comparisons use the parameters truncated to WIDTH; no overflow is possible under the parameter constraint.

## Timing
- First issue is one cycle after `start` (latency 1). Subsequent issues follow every II unstalled cycles.
- With no stalls, run length is TRIPS_OUTER*TRIPS_INNER*II - (II-1) cycles of `busy`.
- `done` is high exactly one cycle, the cycle after the `last` issue, even on back-to-back restart.
- Degenerate 1x1 run: `issue` and `last` are high together in the single RUN cycle.

## Configuration
- Macro `II_LOOP_ISSUER_STALL_EN`.
  - Defined: `stall` behaves as above.
  - Undefined: the `stall` port remains but is ignored (internally tied to 0), and `issue` has no combinational input path.

## Test plan
- Basic nest (TRIPS_OUTER=2, TRIPS_INNER=3, II=2), `start` at cycle 0 → expected response:
  - `issue` at cycles 1, 3, 5, 7, 9, 11.
  - Indices (0,0), (0,1), (0,2), (1,0), (1,1), (1,2).
  - `last` at 11, `done` at 12, `busy` 1..11.
- Stall (1x4, II=1, macro defined), `start` at 0, `stall` high at cycles 2–3 → `issue` at 1, 4, 5, 6; idx_inner 0, 1, 2, 3; `done` at 7. With macro undefined → issues at 1, 2, 3, 4.
- Back-to-back (1x2, II=1), `start` at 0 and 2 → expected response:
  - `issue` at 1, 2, 3, 4, with idx_inner 0, 1, 0, 1.
  - `done` at 3 and 5; `busy` continuous 1..4.
- Ignored start (1x3, II=3), `start` at 0 and again at 4 → issues at 1, 4, 7 only; `done` at 8 only.
- Reset mid-run (2x2, II=1), `start` at 0, `rst` at 2 → cycle 3: `busy`=0, `issue`=0, indices 0; no `done` through cycle 10.
- Degenerate 1x1, II=4, `start` at 0 → `issue` and `last` at 1, `done` at 2, `busy` only at cycle 1.

Source files
------------

// File: rtl/ii_loop_issuer.sv
//------------------------------------------------------------------------------
// Module   : ii_loop_issuer
// Purpose  : Two-level loop-nest issue controller. On a start pulse it issues
//            TRIPS_OUTER*TRIPS_INNER iterations, one every II cycles, each
//            tagged with its outer/inner loop indices. Supports stalls, a
//            final-iteration flag, a one-cycle done pulse and back-to-back
//            restart when start coincides with the final issue.
// Config   : define II_LOOP_ISSUER_STALL_EN to honour the stall input; when it
//            is undefined the stall port is present but ignored, so issue has
//            no combinational input path.
// Ports    : clk        in  clock, rising edge
//            rst        in  synchronous active-high reset
//            start      in  begin a run (also restarts in the last cycle)
//            stall      in  freeze the run for this cycle
//            busy       out run in progress
//            issue      out iteration issued this cycle
//            idx_outer  out outer index of the issued iteration
//            idx_inner  out inner index of the issued iteration
//            last       out this issue is the final iteration
//            done       out one-cycle pulse the cycle after the final issue
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ii_loop_issuer #(
  parameter int WIDTH       = 32,
  parameter int TRIPS_OUTER = 2,
  parameter int TRIPS_INNER = 4,
  parameter int II          = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic             busy,
  output logic             issue,
  output logic [WIDTH-1:0] idx_outer,
  output logic [WIDTH-1:0] idx_inner,
  output logic             last,
  output logic             done
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Gap counter only needs to count 0..II-1; keep at least one bit for II=1.
  localparam int                 c_gap_w     = (II > 1) ? $clog2(II) : 1;
  localparam logic [c_gap_w-1:0] c_gap_max   = c_gap_w'(II - 1);
  localparam logic [c_gap_w-1:0] c_gap_after = (II == 1) ? '0 : c_gap_w'(1);
  localparam logic [WIDTH-1:0]   c_last_out  = WIDTH'(TRIPS_OUTER - 1);
  localparam logic [WIDTH-1:0]   c_last_in   = WIDTH'(TRIPS_INNER - 1);

  state_t             r_state;
  logic [c_gap_w-1:0] r_gap;
  logic [WIDTH-1:0]   r_idx_outer;
  logic [WIDTH-1:0]   r_idx_inner;
  logic               r_done;

  logic               w_stall;
  logic               w_issue;
  logic               w_last;

`ifdef II_LOOP_ISSUER_STALL_EN
  assign w_stall = stall;
`else
  // Port kept for interface compatibility; its value is deliberately dropped.
  logic w_unused_stall;
  assign w_unused_stall = stall;
  assign w_stall        = 1'b0;
`endif

  assign w_issue = (r_state == S_RUN) && (r_gap == '0) && !w_stall;
  assign w_last  = w_issue && (r_idx_outer == c_last_out) && (r_idx_inner == c_last_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_gap       <= '0;
      r_idx_outer <= '0;
      r_idx_inner <= '0;
      r_done      <= 1'b0;
    end else begin
      // done marks the cycle after the final issue, including on restart.
      r_done <= w_last;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_gap       <= '0;
            r_idx_outer <= '0;
            r_idx_inner <= '0;
          end
        end
        S_RUN: begin
          if (w_last) begin
            // start in the final cycle chains straight into a fresh run.
            r_state     <= start ? S_RUN : S_IDLE;
            r_gap       <= '0;
            r_idx_outer <= '0;
            r_idx_inner <= '0;
          end else if (w_issue) begin
            r_gap <= c_gap_after;
            if (r_idx_inner == c_last_in) begin
              r_idx_inner <= '0;
              r_idx_outer <= r_idx_outer + 1'b1;
            end else begin
              r_idx_inner <= r_idx_inner + 1'b1;
            end
          end else if (!w_stall) begin
            r_gap <= (r_gap == c_gap_max) ? '0 : r_gap + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state == S_RUN);
  assign issue     = w_issue;
  assign last      = w_last;
  assign idx_outer = r_idx_outer;
  assign idx_inner = r_idx_inner;
  assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ii_loop_issuer.sv
//------------------------------------------------------------------------------
// Module   : tb_ii_loop_issuer
// Purpose  : Self-checking bench for ii_loop_issuer. Six instances with
//            different loop shapes are exercised one after another with
//            directed cycle-by-cycle stimulus; per-cycle expected outputs are
//            queued as stimulus is applied and popped for comparison.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ii_loop_issuer;

  localparam int N = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] rst_v;
  logic [N-1:0] start_v;
  logic [N-1:0] stall_v;
  logic [N-1:0] busy_v;
  logic [N-1:0] issue_v;
  logic [N-1:0] last_v;
  logic [N-1:0] done_v;
  logic [31:0]  io_v [N];
  logic [31:0]  ii_v [N];

  typedef struct {
    logic        busy;
    logic        issue;
    logic        last;
    logic        done;
    logic        chk_idx;
    logic [31:0] outer;
    logic [31:0] inner;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Basic nest 2x3, II=2
  ii_loop_issuer #(.WIDTH(32), .TRIPS_OUTER(2), .TRIPS_INNER(3), .II(2)) u0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .stall(stall_v[0]),
    .busy(busy_v[0]), .issue(issue_v[0]), .idx_outer(io_v[0]), .idx_inner(ii_v[0]),
    .last(last_v[0]), .done(done_v[0]));
  // Stall 1x4, II=1
  ii_loop_issuer #(.WIDTH(32), .TRIPS_OUTER(1), .TRIPS_INNER(4), .II(1)) u1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .stall(stall_v[1]),
    .busy(busy_v[1]), .issue(issue_v[1]), .idx_outer(io_v[1]), .idx_inner(ii_v[1]),
    .last(last_v[1]), .done(done_v[1]));
  // Back-to-back 1x2, II=1
  ii_loop_issuer #(.WIDTH(32), .TRIPS_OUTER(1), .TRIPS_INNER(2), .II(1)) u2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .stall(stall_v[2]),
    .busy(busy_v[2]), .issue(issue_v[2]), .idx_outer(io_v[2]), .idx_inner(ii_v[2]),
    .last(last_v[2]), .done(done_v[2]));
  // Ignored start 1x3, II=3
  ii_loop_issuer #(.WIDTH(32), .TRIPS_OUTER(1), .TRIPS_INNER(3), .II(3)) u3 (
    .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .stall(stall_v[3]),
    .busy(busy_v[3]), .issue(issue_v[3]), .idx_outer(io_v[3]), .idx_inner(ii_v[3]),
    .last(last_v[3]), .done(done_v[3]));
  // Reset mid-run 2x2, II=1
  ii_loop_issuer #(.WIDTH(32), .TRIPS_OUTER(2), .TRIPS_INNER(2), .II(1)) u4 (
    .clk(clk), .rst(rst_v[4]), .start(start_v[4]), .stall(stall_v[4]),
    .busy(busy_v[4]), .issue(issue_v[4]), .idx_outer(io_v[4]), .idx_inner(ii_v[4]),
    .last(last_v[4]), .done(done_v[4]));
  // Degenerate 1x1, II=4
  ii_loop_issuer #(.WIDTH(32), .TRIPS_OUTER(1), .TRIPS_INNER(1), .II(4)) u5 (
    .clk(clk), .rst(rst_v[5]), .start(start_v[5]), .stall(stall_v[5]),
    .busy(busy_v[5]), .issue(issue_v[5]), .idx_outer(io_v[5]), .idx_inner(ii_v[5]),
    .last(last_v[5]), .done(done_v[5]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle c spans posedge c .. posedge c+1. Inputs for cycle c are driven
  // 1 time unit after posedge c, outputs sampled 1 unit later. idx packs one
  // byte per issue in order: {outer[3:0], inner[3:0]}.
  task automatic run_case(input int k, input int ncyc,
                          input logic [31:0] st, input logic [31:0] sl, input logic [31:0] rs,
                          input logic [31:0] iss, input logic [31:0] lst,
                          input logic [31:0] dn, input logic [31:0] bs,
                          input logic [63:0] idx);
    int   n;
    exp_t e;
    exp_t g;
    n = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      start_v[k] = st[c];
      stall_v[k] = sl[c];
      rst_v[k]   = rs[c];
      e.busy    = bs[c];
      e.issue   = iss[c];
      e.last    = lst[c];
      e.done    = dn[c];
      e.chk_idx = iss[c] || !bs[c];
      e.outer   = '0;
      e.inner   = '0;
      if (iss[c]) begin
        e.outer = 32'(idx[8*n+4 +: 4]);
        e.inner = 32'(idx[8*n   +: 4]);
        n++;
      end
      sb.push_back(e);
      #1;
      g = sb.pop_front();
      chk($sformatf("t%0d c%0d busy", k, c),  32'(busy_v[k]),  32'(g.busy));
      chk($sformatf("t%0d c%0d issue", k, c), 32'(issue_v[k]), 32'(g.issue));
      chk($sformatf("t%0d c%0d last", k, c),  32'(last_v[k]),  32'(g.last));
      chk($sformatf("t%0d c%0d done", k, c),  32'(done_v[k]),  32'(g.done));
      if (g.chk_idx) begin
        chk($sformatf("t%0d c%0d idx_outer", k, c), io_v[k], g.outer);
        chk($sformatf("t%0d c%0d idx_inner", k, c), ii_v[k], g.inner);
      end
    end
    start_v[k] = 1'b0;
    stall_v[k] = 1'b0;
    rst_v[k]   = 1'b0;
  endtask

  initial begin
    rst_v   = '1;
    start_v = '0;
    stall_v = '0;
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst%0d busy", k),  32'(busy_v[k]),  32'd0);
      chk($sformatf("rst%0d issue", k), 32'(issue_v[k]), 32'd0);
      chk($sformatf("rst%0d last", k),  32'(last_v[k]),  32'd0);
      chk($sformatf("rst%0d done", k),  32'(done_v[k]),  32'd0);
      chk($sformatf("rst%0d idx_outer", k), io_v[k], 32'd0);
      chk($sformatf("rst%0d idx_inner", k), ii_v[k], 32'd0);
    end
    rst_v = '0;
    repeat (2) @(posedge clk);

    // Basic nest: issues 1,3,5,7,9,11; last 11; done 12; busy 1..11
    run_case(0, 14, 32'h1, 32'h0, 32'h0, 32'hAAA, 32'h800, 32'h1000, 32'hFFE,
             64'h0000_1211_1002_0100);
    // Stall at cycles 2-3 (and an idle-cycle stall at 8 which must do nothing)
`ifdef II_LOOP_ISSUER_STALL_EN
    run_case(1, 10, 32'h1, 32'h10C, 32'h0, 32'h72, 32'h40, 32'h80, 32'h7E,
             64'h0000_0000_0302_0100);
`else
    run_case(1, 10, 32'h1, 32'h10C, 32'h0, 32'h1E, 32'h10, 32'h20, 32'h1E,
             64'h0000_0000_0302_0100);
`endif
    // Back-to-back restart: start at 0 and 2
    run_case(2, 7, 32'h5, 32'h0, 32'h0, 32'h1E, 32'h14, 32'h28, 32'h1E,
             64'h0000_0000_0100_0100);
    // Start while busy (cycle 4) is ignored
    run_case(3, 10, 32'h11, 32'h0, 32'h0, 32'h92, 32'h80, 32'h100, 32'hFE,
             64'h0000_0000_0002_0100);
    // Reset mid-run at cycle 2: idle from cycle 3, no done
    run_case(4, 11, 32'h1, 32'h0, 32'h4, 32'h6, 32'h0, 32'h0, 32'h6,
             64'h0000_0000_0000_0100);
    // Degenerate 1x1, II=4
    run_case(5, 6, 32'h1, 32'h0, 32'h0, 32'h2, 32'h2, 32'h4, 32'h2,
             64'h0000_0000_0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
